inert_axis_seq: RTL and testbench

INERT_AXIS_SEQ -- requirements
Module: inert_axis_seq

---
 rtl/inert_axis_seq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_inert_axis_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_axis_seq.sv
// inert_axis_seq: sequences an inertial sensor over an SPI monarch.
// After a power-up wait it writes three init registers. From then on, each
// data-ready (INT) starts a burst that reads NUM_AXES 16-bit axes (low byte,
// then high byte) into shadow registers. The burst is then published to
// `rates` as one coherent snapshot, together with a one-clock `vld` pulse.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   INT               sensor data-ready (asynchronous, level-high)
//   clr_err           clears overrun / timeout_err
//   spi_done          one-clock completion pulse from the SPI monarch
//   spi_rspns[15:0]   SPI read data (only [7:0] used)
//   spi_wrt           one-clock transaction start pulse
//   spi_cmd[15:0]     command word, zero whenever spi_wrt is low
//   rates             axis k at [16k+15:16k] = {high byte, low byte}
//   vld               one-clock pulse when rates is updated
//   init_done         high once the init sequence has completed
//   overrun           sticky: INT rose while a burst was in progress
//   timeout_err       sticky: spi_done did not arrive within TMO_CYC clocks
module inert_axis_seq #(
  parameter int unsigned NUM_AXES  = 3,
  parameter logic [6:0]  BASE_ADDR = 7'h22,
  parameter bit          FAST_SIM  = 1'b1,
  parameter int unsigned TMO_CYC   = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    INT,
  input  logic                    clr_err,
  input  logic                    spi_done,
  input  logic [15:0]             spi_rspns,
  output logic                    spi_wrt,
  output logic [15:0]             spi_cmd,
  output logic [16*NUM_AXES-1:0]  rates,
  output logic                    vld,
  output logic                    init_done,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int unsigned PW_BITS = FAST_SIM ? 10 : 16;
  localparam int unsigned PW_LAST = (1 << PW_BITS) - 1;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);
  localparam int unsigned RATES_W = 16 * NUM_AXES;
  localparam int unsigned SHAD_W  = 8 * NUM_AXES;

  localparam logic [15:0]      PW_TC    = 16'(PW_LAST);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [2:0]       K_LAST   = 3'(NUM_AXES - 1);

  // INIT3 is reserved and never entered; the init writes go INIT2 -> INIT_WAIT.
  typedef enum logic [3:0] {
    PWRUP, INIT1, INIT2, INIT3, INIT_WAIT, IDLE, RD_LO, RD_HI, PUBLISH
  } state_t;

  state_t state, state_nxt;

  logic                int_s1, int_s2, int_d;
  logic                int_s, int_rise;
  logic [15:0]         pw_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [2:0]          k;
  logic [2:0]          k_plus;
  logic [SHAD_W-1:0]   shad_lo, shad_hi;
  logic [RATES_W-1:0]  rates_nxt;
  logic [6:0]          addr_lo, addr_hi, addr_nx;

  logic                wrt_nxt, vld_nxt, init_done_nxt;
  logic [15:0]         cmd_nxt;
  logic                ovr_set, tmo_set, waiting, tmo_hit;
  logic                cap_lo, cap_hi, k_clr, k_inc, publish;

  logic                unused_rspns;
  assign unused_rspns = ^spi_rspns[15:8];

  // INT synchronizer plus one extra flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
      int_d  <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
      int_d  <= int_s2;
    end
  end

  assign int_s    = int_s2;
  assign int_rise = int_s2 & ~int_d;

  // Register addresses; 7-bit sums wrap modulo 128 by construction.
  assign k_plus  = k + 3'd1;
  assign addr_lo = BASE_ADDR + {3'b000, k, 1'b0};
  assign addr_hi = BASE_ADDR + {3'b000, k, 1'b1};
  assign addr_nx = BASE_ADDR + {3'b000, k_plus, 1'b0};

  // The last high byte arrives in the publish cycle, so it bypasses the shadow.
  always_comb begin
    rates_nxt = '0;
    for (int a = 0; a < int'(NUM_AXES); a++) begin
      if (a == int'(NUM_AXES) - 1)
        rates_nxt[16*a +: 16] = {spi_rspns[7:0], shad_lo[8*a +: 8]};
      else
        rates_nxt[16*a +: 16] = {shad_hi[8*a +: 8], shad_lo[8*a +: 8]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PWRUP;
    else        state <= state_nxt;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    wrt_nxt       = 1'b0;
    cmd_nxt       = 16'h0000;
    vld_nxt       = 1'b0;
    init_done_nxt = init_done;
    ovr_set       = 1'b0;
    tmo_set       = 1'b0;
    waiting       = 1'b0;
    cap_lo        = 1'b0;
    cap_hi        = 1'b0;
    k_clr         = 1'b0;
    k_inc         = 1'b0;
    publish       = 1'b0;
    tmo_hit       = (tmo_cnt == TMO_LAST) && !spi_done;

    unique case (state)
      PWRUP: begin
        if (pw_cnt == PW_TC) begin
          wrt_nxt   = 1'b1;
          cmd_nxt   = 16'h0D02;
          state_nxt = INIT1;
        end
      end
      INIT1: begin
        waiting = 1'b1;
        if (spi_done) begin
          wrt_nxt   = 1'b1;
          cmd_nxt   = 16'h1160;
          state_nxt = INIT2;
        end
      end
      INIT2: begin
        waiting = 1'b1;
        if (spi_done) begin
          wrt_nxt   = 1'b1;
          cmd_nxt   = 16'h1440;
          state_nxt = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        waiting = 1'b1;
        if (spi_done) begin
          init_done_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      IDLE: begin
        if (int_s) begin
          k_clr     = 1'b1;
          wrt_nxt   = 1'b1;
          cmd_nxt   = {1'b1, BASE_ADDR, 8'h00};
          state_nxt = RD_LO;
        end
      end
      RD_LO: begin
        waiting = 1'b1;
        ovr_set = int_rise;
        if (spi_done) begin
          cap_lo    = 1'b1;
          wrt_nxt   = 1'b1;
          cmd_nxt   = {1'b1, addr_hi, 8'h00};
          state_nxt = RD_HI;
        end
      end
      RD_HI: begin
        waiting = 1'b1;
        ovr_set = int_rise;
        if (spi_done) begin
          cap_hi = 1'b1;
          if (k != K_LAST) begin
            k_inc     = 1'b1;
            wrt_nxt   = 1'b1;
            cmd_nxt   = {1'b1, addr_nx, 8'h00};
            state_nxt = RD_LO;
          end else begin
            publish   = 1'b1;
            vld_nxt   = 1'b1;
            state_nxt = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        ovr_set   = int_rise;
        state_nxt = IDLE;
      end
      default: state_nxt = PWRUP;
    endcase

    // tmo_hit excludes spi_done, so no transaction actions are active here.
    if (waiting && tmo_hit) begin
      tmo_set   = 1'b1;
      state_nxt = init_done ? IDLE : PWRUP;
    end
  end

  // Power-up wait counter; held at zero outside PWRUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pw_cnt <= 16'h0000;
    else if (state == PWRUP) pw_cnt <= pw_cnt + 16'd1;
    else                     pw_cnt <= 16'h0000;
  end

  // Transaction timeout counter; restarts with every issued command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tmo_cnt <= '0;
    else if (wrt_nxt) tmo_cnt <= '0;
    else if (waiting) tmo_cnt <= tmo_cnt + TMO_W'(1);
    else              tmo_cnt <= '0;
  end

  // Axis index and shadow byte capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= 3'd0;
      shad_lo <= '0;
      shad_hi <= '0;
    end else begin
      if (k_clr)      k <= 3'd0;
      else if (k_inc) k <= k_plus;
      for (int a = 0; a < int'(NUM_AXES); a++) begin
        if (cap_lo && k == 3'(a)) shad_lo[8*a +: 8] <= spi_rspns[7:0];
        if (cap_hi && k == 3'(a)) shad_hi[8*a +: 8] <= spi_rspns[7:0];
      end
    end
  end

  // Registered outputs; set wins over clr_err on the sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_wrt     <= 1'b0;
      spi_cmd     <= 16'h0000;
      vld         <= 1'b0;
      init_done   <= 1'b0;
      rates       <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      spi_wrt     <= wrt_nxt;
      spi_cmd     <= cmd_nxt;
      vld         <= vld_nxt;
      init_done   <= init_done_nxt;
      if (publish) rates <= rates_nxt;
      overrun     <= ovr_set | (overrun & ~clr_err);
      timeout_err <= tmo_set | (timeout_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_inert_axis_seq.sv
// Testbench for inert_axis_seq: two instances (default 3-axis, and a 1-axis
// instance at address 7'h7F), behavioural SPI responders, and a scoreboard
// of expected commands and published rates.
module tb_inert_axis_seq;

  localparam int LAT_A = 8;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        int_a, clr_a, done_a;
  logic [15:0] rsp_a;
  logic        wrt_a, vld_a, initd_a, ovr_a, tmo_a;
  logic [15:0] cmd_a;
  logic [47:0] rates_a;

  logic        int_b, clr_b, done_b;
  logic [15:0] rsp_b;
  logic        wrt_b, vld_b, initd_b, ovr_b, tmo_b;
  logic [15:0] cmd_b;
  logic [15:0] rates_b;

  inert_axis_seq dut_a (
    .clk(clk), .rst_n(rst_n), .INT(int_a), .clr_err(clr_a),
    .spi_done(done_a), .spi_rspns(rsp_a), .spi_wrt(wrt_a), .spi_cmd(cmd_a),
    .rates(rates_a), .vld(vld_a), .init_done(initd_a), .overrun(ovr_a),
    .timeout_err(tmo_a)
  );

  inert_axis_seq #(.NUM_AXES(1), .BASE_ADDR(7'h7F)) dut_b (
    .clk(clk), .rst_n(rst_n), .INT(int_b), .clr_err(clr_b),
    .spi_done(done_b), .spi_rspns(rsp_b), .spi_wrt(wrt_b), .spi_cmd(cmd_b),
    .rates(rates_b), .vld(vld_b), .init_done(initd_b), .overrun(ovr_b),
    .timeout_err(tmo_b)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned last_done_a = 0, last_done_b = 0;
  int          vld_cnt_a = 0, vld_cnt_b = 0;
  int          idle_viol = 0;
  bit          hold_a = 1'b0;

  logic [15:0] exp_cmd_a[$];
  logic [15:0] exp_cmd_b[$];
  logic [47:0] exp_rates_a[$];
  logic [15:0] exp_rates_b[$];
  logic [7:0]  rsp_q_a[$];
  logic [7:0]  rsp_q_b[$];

  typedef struct {
    logic [5:0][7:0] rsp;
    logic [47:0]     exp_rates;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, msg);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI responder A: done LAT_A clocks after spi_wrt, unless held.
  initial begin
    done_a = 1'b0;
    rsp_a  = 16'h0000;
    forever begin
      @(negedge clk);
      done_a = 1'b0;
      if (wrt_a && !hold_a) begin
        repeat (LAT_A - 1) @(negedge clk);
        if (rsp_q_a.size() > 0) rsp_a = {8'hA5, rsp_q_a.pop_front()};
        else                    rsp_a = 16'hA500;
        done_a      = 1'b1;
        last_done_a = cyc;
      end
    end
  end

  // SPI responder B.
  initial begin
    done_b = 1'b0;
    rsp_b  = 16'h0000;
    forever begin
      @(negedge clk);
      done_b = 1'b0;
      if (wrt_b) begin
        repeat (LAT_B - 1) @(negedge clk);
        if (rsp_q_b.size() > 0) rsp_b = {8'h5A, rsp_q_b.pop_front()};
        else                    rsp_b = 16'h5A00;
        done_b      = 1'b1;
        last_done_b = cyc;
      end
    end
  end

  // Scoreboard: compare every issued command and every publish.
  always @(negedge clk) begin
    if (wrt_a) begin
      if (exp_cmd_a.size() == 0) fail_now("unexp_wrt_a", $sformatf("got cmd 0x%h, expected none", cmd_a));
      else check("cmd_a", 64'(cmd_a), 64'(exp_cmd_a.pop_front()));
    end else if (cmd_a != 16'h0000 || cmd_b != 16'h0000 && !wrt_b) begin
      idle_viol++;
    end
    if (wrt_b) begin
      if (exp_cmd_b.size() == 0) fail_now("unexp_wrt_b", $sformatf("got cmd 0x%h, expected none", cmd_b));
      else check("cmd_b", 64'(cmd_b), 64'(exp_cmd_b.pop_front()));
    end else if (cmd_b != 16'h0000) begin
      idle_viol++;
    end
    if (vld_a) begin
      vld_cnt_a++;
      if (exp_rates_a.size() == 0) fail_now("unexp_vld_a", $sformatf("rates 0x%h", rates_a));
      else begin
        check("rates_a", 64'(rates_a), 64'(exp_rates_a.pop_front()));
        check("vld_lat_a", 64'(cyc), 64'(last_done_a + 1));
      end
    end
    if (vld_b) begin
      vld_cnt_b++;
      if (exp_rates_b.size() == 0) fail_now("unexp_vld_b", $sformatf("rates 0x%h", rates_b));
      else begin
        check("rates_b", 64'(rates_b), 64'(exp_rates_b.pop_front()));
        check("vld_lat_b", 64'(cyc), 64'(last_done_b + 1));
      end
    end
  end

  task automatic wait_wrt_a(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (wrt_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_wrt_a", "no spi_wrt within cycle budget");
  endtask

  task automatic wait_vld_a(input int target, input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (vld_cnt_a >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_vld_a", "no vld within cycle budget");
  endtask

  // One 3-axis burst on A; optional INT re-pulse while reading axis 0 high.
  task automatic run_burst_a(input logic [5:0][7:0] rsp, input logic [47:0] exp, input bit poke);
    bit ok;
    int target;
    for (int i = 0; i < 6; i++) rsp_q_a.push_back(rsp[i]);
    for (int i = 0; i < 6; i++) exp_cmd_a.push_back(16'hA200 + 16'(i * 256));
    exp_rates_a.push_back(exp);
    target = vld_cnt_a + 1;
    int_a = 1'b1;
    wait_wrt_a(50, ok);
    int_a = 1'b0;
    if (poke) begin
      wait_wrt_a(50, ok);
      int_a = 1'b1;
      repeat (2) @(negedge clk);
      int_a = 1'b0;
    end
    wait_vld_a(target, 500);
    repeat (10) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int          n;
    bit          ok;
    int          vld_before;
    logic [47:0] last_rates;

    vecs[0] = '{rsp: {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, exp_rates: 48'h6655_4433_2211};
    vecs[1] = '{rsp: {8'hC3, 8'h7E, 8'h00, 8'hFF, 8'h80, 8'h01}, exp_rates: 48'hC37E_00FF_8001};
    vecs[2] = '{rsp: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, exp_rates: 48'hFFFF_FFFF_FFFF};
    vecs[3] = '{rsp: {8'hF0, 8'h0F, 8'hC3, 8'h3C, 8'h5A, 8'hA5}, exp_rates: 48'hF00F_C33C_5AA5};

    rst_n = 1'b0;
    int_a = 1'b0; clr_a = 1'b0;
    int_b = 1'b0; clr_b = 1'b0;
    exp_cmd_a.push_back(16'h0D02); exp_cmd_a.push_back(16'h1160); exp_cmd_a.push_back(16'h1440);
    exp_cmd_b.push_back(16'h0D02); exp_cmd_b.push_back(16'h1160); exp_cmd_b.push_back(16'h1440);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_wrt", 64'(wrt_a), 64'd0);
    check("rst_cmd", 64'(cmd_a), 64'd0);
    check("rst_rates", 64'(rates_a), 64'd0);
    check("rst_vld", 64'(vld_a), 64'd0);
    check("rst_init_done", 64'(initd_a), 64'd0);
    check("rst_flags", 64'({ovr_a, tmo_a}), 64'd0);

    // Power-up wait and init sequence.
    @(negedge clk);
    rst_n = 1'b1;
    for (n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (wrt_a) break;
    end
    check("pwrup_wait", 64'(n), 64'd1024);
    wait_wrt_a(50, ok);
    wait_wrt_a(50, ok);
    check("init_done_early", 64'(initd_a), 64'd0);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (initd_a) break;
    end
    check("init_done", 64'(initd_a), 64'd1);
    check("init_done_lat", 64'(cyc), 64'(last_done_a + 1));
    repeat (10) @(negedge clk);
    check("init_done_b", 64'(initd_b), 64'd1);

    // Table-driven bursts.
    for (int v = 0; v < 4; v++) begin
      run_burst_a(vecs[v].rsp, vecs[v].exp_rates, 1'b0);
      check("rates_hold", 64'(rates_a), 64'(vecs[v].exp_rates));
    end
    check("no_overrun", 64'(ovr_a), 64'd0);
    check("vld_count", 64'(vld_cnt_a), 64'd4);

    // Overrun: INT re-rises mid-burst; burst still publishes; clr_err clears.
    run_burst_a(vecs[0].rsp, vecs[0].exp_rates, 1'b1);
    check("overrun_set", 64'(ovr_a), 64'd1);
    check("overrun_no_tmo", 64'(tmo_a), 64'd0);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("overrun_clr", 64'(ovr_a), 64'd0);
    last_rates = vecs[0].exp_rates;

    // Timeout: spi_done withheld in RD_LO.
    hold_a = 1'b1;
    exp_cmd_a.push_back(16'hA200);
    vld_before = vld_cnt_a;
    int_a = 1'b1;
    wait_wrt_a(50, ok);
    int_a = 1'b0;
    for (n = 1; n <= 5000; n++) begin
      @(negedge clk);
      if (tmo_a) break;
    end
    check("tmo_cycles", 64'(n), 64'd4096);
    check("tmo_err", 64'(tmo_a), 64'd1);
    repeat (20) @(negedge clk);
    hold_a = 1'b0;
    check("tmo_no_vld", 64'(vld_cnt_a), 64'(vld_before));
    check("tmo_rates", 64'(rates_a), 64'(last_rates));
    check("tmo_no_cmds", 64'(exp_cmd_a.size()), 64'd0);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("tmo_clr", 64'(tmo_a), 64'd0);
    run_burst_a(vecs[1].rsp, vecs[1].exp_rates, 1'b0);
    check("tmo_recover", 64'(rates_a), 64'(vecs[1].exp_rates));

    // Single axis with address wrap 7F -> 00.
    rsp_q_b.push_back(8'hEF);
    rsp_q_b.push_back(8'hBE);
    exp_cmd_b.push_back(16'hFF00);
    exp_cmd_b.push_back(16'h8000);
    exp_rates_b.push_back(16'hBEEF);
    int_b = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (wrt_b) break;
    end
    int_b = 1'b0;
    repeat (40) @(negedge clk);
    check("b_vld_count", 64'(vld_cnt_b), 64'd1);
    check("b_rates", 64'(rates_b), 64'h0000_BEEF);
    check("b_cmds_done", 64'(exp_cmd_b.size()), 64'd0);

    // Reset mid-burst aborts with no vld and clears rates.
    vld_before = vld_cnt_a;
    for (int i = 0; i < 6; i++) rsp_q_a.push_back(8'h99);
    exp_cmd_a.push_back(16'hA200);
    int_a = 1'b1;
    wait_wrt_a(50, ok);
    int_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rates", 64'(rates_a), 64'd0);
    check("abort_init_done", 64'(initd_a), 64'd0);
    repeat (30) @(negedge clk);
    check("abort_no_vld", 64'(vld_cnt_a), 64'(vld_before));
    check("abort_outputs", 64'({wrt_a, vld_a, ovr_a, tmo_a}), 64'd0);

    check("cmd_zero_when_idle", 64'(idle_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
